// File: rtl/issue_pkg.sv
// Shared types and default sizes for the issue scheduler and its lock-file interface.
package issue_pkg;

    typedef enum logic [0:0] {
        SWEEP,
        RUN
    } sched_state_t;

    localparam int unsigned XWDT_DEF = 6;
    localparam int unsigned XN_DEF   = 1 << XWDT_DEF;

endpackage

// File: rtl/issue_sched_if.sv
// Decode/execute handshake, lock-file and writeback signals bundled for the issue scheduler.
interface issue_sched_if import issue_pkg::*; #(
    parameter int unsigned XWDT = XWDT_DEF,
    parameter int unsigned XN   = XN_DEF,
    parameter int unsigned NFU  = 2
);
    logic                  id_valid;
    logic                  id_ready;
    logic [XWDT-1:0]       id_rs1;
    logic [XWDT-1:0]       id_rs2;
    logic [XWDT-1:0]       id_rd;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  iss_valid;
    logic                  iss_ready;
    logic [XN-1:0]         rlocks;
    logic [XWDT-1:0]       rset;
    logic [XWDT-1:0]       rclear;
    logic [NFU-1:0]        wb_req;
    logic [NFU*XWDT-1:0]   wb_rd;
    logic [NFU-1:0]        wb_gnt;
    logic [31:0]           stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
        output iss_ready, rlocks, wb_req, wb_rd,
        input  id_ready, iss_valid, rset, rclear, wb_gnt, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
        input  iss_ready, rlocks, wb_req, wb_rd,
        output id_ready, iss_valid, rset, rclear, wb_gnt, stall_cnt
    );

endinterface

// File: rtl/wb_rr_arb.sv
// Round-robin arbiter for functional-unit writebacks; grants the first requester at or
// after the pointer and advances the pointer past the winner.
module wb_rr_arb #(
    parameter int unsigned NFU = 2,
    parameter int unsigned GW  = (NFU > 1) ? $clog2(NFU) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_en,
    input  logic [NFU-1:0] i_req,
    output logic [NFU-1:0] o_gnt,
    output logic [GW-1:0]  o_gnt_idx
);

    logic [GW-1:0] r_ptr;
    logic [GW-1:0] w_ptr_d;
    logic [GW-1:0] w_idx;
    logic          w_found;
    int unsigned   w_cand;

    always_comb begin
        o_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < NFU; k++) begin
            w_cand = (32'(r_ptr) + 32'(k)) % NFU;
            if (i_en && !w_found && i_req[w_cand[GW-1:0]]) begin
                w_found                = 1'b1;
                w_idx                  = w_cand[GW-1:0];
                o_gnt[w_cand[GW-1:0]]  = 1'b1;
            end
        end
        w_ptr_d = r_ptr;
        if (w_found) begin
            w_ptr_d = (w_idx == GW'(NFU - 1)) ? '0 : w_idx + GW'(1);
        end
    end

    assign o_gnt_idx = w_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_d;
        end
    end

endmodule

// File: rtl/issue_sched.sv
// Issue scheduler: stalls on locked source/destination registers, sets locks on issue,
// arbitrates writeback clears, and sweeps the (reset-less) lock file clear after reset.
module issue_sched import issue_pkg::*; #(
    parameter int unsigned XWDT = XWDT_DEF,
    parameter int unsigned XN   = XN_DEF,
    parameter int unsigned NFU  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    issue_sched_if.slave  bus
);

    localparam int unsigned GW = (NFU > 1) ? $clog2(NFU) : 1;

    sched_state_t    r_state, w_state_d;
    logic [XWDT-1:0] r_sweep_idx, w_sweep_idx_d;
    logic [31:0]     r_stall_cnt;
    logic            w_run, w_src_haz, w_waw_haz, w_hazard, w_fire;
    logic [NFU-1:0]  w_gnt;
    logic [GW-1:0]   w_gnt_idx;

    assign w_run     = (r_state == RUN);
    assign w_src_haz = (bus.id_use_rs1 && (bus.id_rs1 != '0) && bus.rlocks[bus.id_rs1]) ||
                       (bus.id_use_rs2 && (bus.id_rs2 != '0) && bus.rlocks[bus.id_rs2]);
    assign w_waw_haz = (bus.id_rd != '0) && bus.rlocks[bus.id_rd];
    assign w_hazard  = w_src_haz || w_waw_haz;
    assign w_fire    = w_run && bus.id_valid && bus.iss_ready && !w_hazard;

    wb_rr_arb #(
        .NFU (NFU),
        .GW  (GW)
    ) u_wb_rr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_run),
        .i_req     (bus.wb_req),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_state_d     = r_state;
        w_sweep_idx_d = r_sweep_idx;
        bus.id_ready  = 1'b0;
        bus.iss_valid = 1'b0;
        bus.rset      = '0;
        bus.rclear    = '0;
        bus.wb_gnt    = '0;
        unique case (r_state)
            SWEEP: begin
                bus.rclear    = r_sweep_idx;
                w_sweep_idx_d = r_sweep_idx + XWDT'(1);
                if (r_sweep_idx == XWDT'(XN - 1)) begin
                    w_state_d = RUN;
                end
            end
            RUN: begin
                bus.iss_valid = bus.id_valid && !w_hazard;
                bus.id_ready  = bus.iss_ready && !w_hazard;
                bus.rset      = w_fire ? bus.id_rd : '0;
                bus.wb_gnt    = w_gnt;
                if (|w_gnt) begin
                    bus.rclear = bus.wb_rd[w_gnt_idx*XWDT +: XWDT];
                end
            end
            default: begin
                w_state_d = SWEEP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SWEEP;
            r_sweep_idx <= XWDT'(1);
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_sweep_idx <= w_sweep_idx_d;
            if (w_run && bus.id_valid && w_hazard) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_issue_sched.sv
// Directed self-checking bench for issue_sched: sweep, hazards, issue, round-robin and reset.
module tb_issue_sched;
    localparam int unsigned XWDT = 6;
    localparam int unsigned XN   = 64;
    localparam int unsigned NFU  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   exp_stall = 0;

    always #5 clk = ~clk;

    issue_sched_if #(.XWDT(XWDT), .XN(XN), .NFU(NFU)) bus ();

    issue_sched #(.XWDT(XWDT), .XN(XN), .NFU(NFU)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid   = 1'b0;
        bus.id_rs1     = '0;
        bus.id_rs2     = '0;
        bus.id_rd      = '0;
        bus.id_use_rs1 = 1'b0;
        bus.id_use_rs2 = 1'b0;
        bus.iss_ready  = 1'b1;
        bus.rlocks     = '0;
        bus.wb_req     = '0;
        bus.wb_rd      = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.id_valid = 1'b1;
        bus.wb_req   = 2'b11;
        rst_n        = 1'b0;
        repeat (2) tick();
        #1;
        checks++;
        if (bus.id_ready !== 1'b0 || bus.iss_valid !== 1'b0 || bus.rset !== 6'd0 ||
            bus.wb_gnt !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: id_ready=%b iss_valid=%b rset=%0d wb_gnt=%b, want 0 0 0 00",
                     bus.id_ready, bus.iss_valid, bus.rset, bus.wb_gnt);
        end
        checks++;
        if (bus.stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt);
        end
    endtask

    task automatic test_sweep();
        logic [XWDT-1:0] e;
        tick();
        bus.id_valid   = 1'b1;
        bus.id_rs1     = 6'd5;
        bus.id_use_rs1 = 1'b1;
        bus.rlocks[5]  = 1'b1;
        bus.wb_req     = 2'b11;
        bus.wb_rd      = {6'd9, 6'd3};
        rst_n          = 1'b1;
        for (int k = 0; k < 63; k++) begin
            #1;
            e = XWDT'(k + 1);
            checks++;
            if (bus.rclear !== e || bus.id_ready !== 1'b0 || bus.iss_valid !== 1'b0 ||
                bus.wb_gnt !== 2'b00 || bus.rset !== 6'd0) begin
                failures++;
                $display("FAIL sweep cyc=%0d: rclear=%0d id_ready=%b iss_valid=%b gnt=%b rset=%0d, want rclear=%0d others 0",
                         k, bus.rclear, bus.id_ready, bus.iss_valid, bus.wb_gnt, bus.rset, e);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (bus.id_ready !== 1'b1 || bus.rclear !== 6'd0 || bus.stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL sweep_end: id_ready=%b rclear=%0d stall_cnt=%0d, want 1 0 0",
                     bus.id_ready, bus.rclear, bus.stall_cnt);
        end
        tick();
    endtask

    task automatic test_raw();
        bus.rlocks[5]  = 1'b1;
        bus.id_valid   = 1'b1;
        bus.id_rs1     = 6'd5;
        bus.id_use_rs1 = 1'b1;
        #1;
        checks++;
        if (bus.id_ready !== 1'b0 || bus.iss_valid !== 1'b0 || bus.rset !== 6'd0) begin
            failures++;
            $display("FAIL raw_stall: id_ready=%b iss_valid=%b rset=%0d, want 0 0 0",
                     bus.id_ready, bus.iss_valid, bus.rset);
        end
        tick();
        exp_stall++;
        #1;
        checks++;
        if (bus.stall_cnt !== 32'(exp_stall) || bus.iss_valid !== 1'b0) begin
            failures++;
            $display("FAIL raw_stall_cnt: stall_cnt=%0d iss_valid=%b, want %0d 0",
                     bus.stall_cnt, bus.iss_valid, exp_stall);
        end
        tick();
        exp_stall++;
        bus.rlocks[5] = 1'b0;
        #1;
        checks++;
        if (bus.iss_valid !== 1'b1 || bus.id_ready !== 1'b1 || bus.rset !== 6'd0 ||
            bus.stall_cnt !== 32'(exp_stall)) begin
            failures++;
            $display("FAIL raw_release: iss_valid=%b id_ready=%b rset=%0d stall_cnt=%0d, want 1 1 0 %0d",
                     bus.iss_valid, bus.id_ready, bus.rset, bus.stall_cnt, exp_stall);
        end
        tick();
        // rs2-only hazard
        idle();
        bus.rlocks[12] = 1'b1;
        bus.id_valid   = 1'b1;
        bus.id_rs2     = 6'd12;
        bus.id_use_rs2 = 1'b1;
        #1;
        checks++;
        if (bus.iss_valid !== 1'b0 || bus.id_ready !== 1'b0) begin
            failures++;
            $display("FAIL rs2_stall: iss_valid=%b id_ready=%b, want 0 0",
                     bus.iss_valid, bus.id_ready);
        end
        tick();
        exp_stall++;
        bus.rlocks[12] = 1'b0;
        #1;
        checks++;
        if (bus.iss_valid !== 1'b1 || bus.stall_cnt !== 32'(exp_stall)) begin
            failures++;
            $display("FAIL rs2_release: iss_valid=%b stall_cnt=%0d, want 1 %0d",
                     bus.iss_valid, bus.stall_cnt, exp_stall);
        end
        tick();
        idle();
    endtask

    task automatic test_unused();
        bus.rlocks[5]  = 1'b1;
        bus.rlocks[0]  = 1'b1;
        bus.id_valid   = 1'b1;
        bus.id_rs1     = 6'd5;
        bus.id_use_rs1 = 1'b0;
        bus.id_rs2     = 6'd0;
        bus.id_use_rs2 = 1'b1;
        bus.id_rd      = 6'd0;
        #1;
        checks++;
        if (bus.iss_valid !== 1'b1 || bus.id_ready !== 1'b1 || bus.rset !== 6'd0) begin
            failures++;
            $display("FAIL unused_zero: iss_valid=%b id_ready=%b rset=%0d, want 1 1 0",
                     bus.iss_valid, bus.id_ready, bus.rset);
        end
        bus.id_rd     = 6'd20;
        bus.iss_ready = 1'b0;
        #1;
        checks++;
        if (bus.iss_valid !== 1'b1 || bus.id_ready !== 1'b0 || bus.rset !== 6'd0) begin
            failures++;
            $display("FAIL exec_backpressure: iss_valid=%b id_ready=%b rset=%0d, want 1 0 0",
                     bus.iss_valid, bus.id_ready, bus.rset);
        end
        bus.iss_ready = 1'b1;
        #1;
        checks++;
        if (bus.rset !== 6'd20 || bus.stall_cnt !== 32'(exp_stall)) begin
            failures++;
            $display("FAIL issue_rset: rset=%0d stall_cnt=%0d, want 20 %0d",
                     bus.rset, bus.stall_cnt, exp_stall);
        end
        tick();
        idle();
    endtask

    task automatic test_waw();
        bus.rlocks[7] = 1'b1;
        bus.id_valid  = 1'b1;
        bus.id_rd     = 6'd7;
        #1;
        checks++;
        if (bus.iss_valid !== 1'b0 || bus.id_ready !== 1'b0 || bus.rset !== 6'd0) begin
            failures++;
            $display("FAIL waw_stall: iss_valid=%b id_ready=%b rset=%0d, want 0 0 0",
                     bus.iss_valid, bus.id_ready, bus.rset);
        end
        tick();
        exp_stall++;
        bus.wb_req = 2'b10;
        bus.wb_rd  = {6'd7, 6'd0};
        #1;
        checks++;
        if (bus.wb_gnt !== 2'b10 || bus.rclear !== 6'd7 || bus.iss_valid !== 1'b0 ||
            bus.rset !== 6'd0) begin
            failures++;
            $display("FAIL waw_no_forward: gnt=%b rclear=%0d iss_valid=%b rset=%0d, want 10 7 0 0",
                     bus.wb_gnt, bus.rclear, bus.iss_valid, bus.rset);
        end
        tick();
        exp_stall++;
        bus.rlocks[7] = 1'b0;
        bus.wb_req    = 2'b00;
        #1;
        checks++;
        if (bus.iss_valid !== 1'b1 || bus.rset !== 6'd7 || bus.rclear !== 6'd0 ||
            bus.wb_gnt !== 2'b00 || bus.stall_cnt !== 32'(exp_stall)) begin
            failures++;
            $display("FAIL waw_issue: iss_valid=%b rset=%0d rclear=%0d gnt=%b stall_cnt=%0d, want 1 7 0 00 %0d",
                     bus.iss_valid, bus.rset, bus.rclear, bus.wb_gnt, bus.stall_cnt, exp_stall);
        end
        tick();
        idle();
    endtask

    task automatic test_round_robin();
        logic [NFU-1:0]  eg [7];
        logic [XWDT-1:0] er [7];
        logic [NFU-1:0]  rq [7];
        eg = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b00, 2'b10, 2'b01};
        er = '{6'd3,  6'd9,  6'd3,  6'd3,  6'd0,  6'd9,  6'd3};
        rq = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b11, 2'b11};
        bus.wb_rd = {6'd9, 6'd3};
        for (int i = 0; i < 7; i++) begin
            bus.wb_req = rq[i];
            #1;
            checks++;
            if (bus.wb_gnt !== eg[i] || bus.rclear !== er[i]) begin
                failures++;
                $display("FAIL rr step=%0d: gnt=%b rclear=%0d, want %b %0d",
                         i, bus.wb_gnt, bus.rclear, eg[i], er[i]);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        bus.wb_req   = 2'b11;
        bus.wb_rd    = {6'd9, 6'd3};
        bus.id_valid = 1'b1;
        bus.id_rd    = 6'd0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.iss_valid !== 1'b0 || bus.id_ready !== 1'b0 || bus.rset !== 6'd0 ||
            bus.wb_gnt !== 2'b00 || bus.stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL midreset_outputs: iss_valid=%b id_ready=%b rset=%0d gnt=%b stall_cnt=%0d, want 0 0 0 00 0",
                     bus.iss_valid, bus.id_ready, bus.rset, bus.wb_gnt, bus.stall_cnt);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.rclear !== 6'd1 || bus.wb_gnt !== 2'b00 || bus.id_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_restart: rclear=%0d gnt=%b id_ready=%b, want 1 00 0",
                     bus.rclear, bus.wb_gnt, bus.id_ready);
        end
        repeat (62) tick();
        #1;
        checks++;
        if (bus.rclear !== 6'd63 || bus.id_ready !== 1'b0 || bus.wb_gnt !== 2'b00) begin
            failures++;
            $display("FAIL midreset_last_sweep: rclear=%0d id_ready=%b gnt=%b, want 63 0 00",
                     bus.rclear, bus.id_ready, bus.wb_gnt);
        end
        tick();
        #1;
        checks++;
        if (bus.wb_gnt !== 2'b01 || bus.rclear !== 6'd3 || bus.id_ready !== 1'b1 ||
            bus.iss_valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_run: gnt=%b rclear=%0d id_ready=%b iss_valid=%b, want 01 3 1 1",
                     bus.wb_gnt, bus.rclear, bus.id_ready, bus.iss_valid);
        end
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_raw();
        test_unused();
        test_waw();
        test_round_robin();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_sched.md
# issue_sched

Issue scheduler and lock-file controller for the core's register scoreboard. It sits between decode and execute. It stalls an instruction whose source or destination register is locked and drives the lock file's `rset` port when an instruction issues. It also round-robin arbitrates functional-unit writebacks onto the lock file's single `rclear` port. After reset it sweeps the lock file clear, because the lock file itself has no reset.

## Interface
- `XWDT`, 6, register index width
- `XN`, 64, number of architectural registers (2**XWDT)
- `NFU`, 2, number of writeback requesters (functional units), ≥1
---
- `clk`  in  1  clock, all state on posedge
- `rst_n`  in  1  reset, asynchronous, active-low
- `id_valid`  in  1  decode offers an instruction
- `id_ready`  out  1  scheduler accepts it this cycle
- `id_rs1`, `id_rs2`, `id_rd`  in  XWDT each  register indices; 0 means none
- `id_use_rs1`, `id_use_rs2`  in  1 each  source operand is actually read
- `iss_valid`  out  1  instruction issued to execute
- `iss_ready`  in  1  execute can accept
- `rlocks`  in  XN  lock vector from the lock file
- `rset`  out  XWDT  lock to set; 0 means none
- `rclear`  out  XWDT  lock to clear; 0 means none
- `wb_req`  in  NFU  per-FU writeback request, held until granted
- `wb_rd`  in  NFU*XWDT  per-FU destination; slice i belongs to FU i
- `wb_gnt`  out  NFU  one-hot grant; zero when nothing is granted
- `stall_cnt`  out  32  count of cycles stalled by a hazard

## Operation
- States are `SWEEP` and `RUN`. Reset enters `SWEEP` with `sweep_idx`=1.
- **`SWEEP`**
  - `rclear`=`sweep_idx`, `rset`=0, `id_ready`=0, `iss_valid`=0, `wb_gnt`=0.
  - `sweep_idx` increments each cycle.
  - After the cycle with `sweep_idx`=XN-1, the block moves to `RUN`. The sweep therefore lasts XN-1 cycles.
- **Hazard** (`RUN` only):
  - Source hazard: (`id_use_rs1` & `id_rs1`≠0 & `rlocks[id_rs1]`), or the same condition for rs2.
  - WAW hazard: `id_rd`≠0 & `rlocks[id_rd]`.
  - Register 0 never creates a hazard and is never set.
- **Issue** (combinational):
  - `iss_valid` = RUN & `id_valid` & !hazard.
  - `id_ready` = RUN & `iss_ready` & !hazard.
  - Fire = `iss_valid` & `iss_ready`.
  - `rset` = fire ? `id_rd` : 0.
- **Writeback arbitration** (`RUN` only):
  - Grant the first requesting FU at or after `rr_ptr`, wrapping modulo NFU.
  - `rclear` = `wb_rd` of the granted FU; `rclear`=0 when there is no request.
  - On a grant to FU g, `rr_ptr` becomes (g+1) mod NFU. With no grant, `rr_ptr` holds.
- **`stall_cnt`** increments in `RUN` when `id_valid` & hazard. It wraps at 2^32.
- **No forwarding.** A register cleared in cycle t is still locked in `rlocks` at t. A dependent instruction therefore issues no earlier than t+1.
- **Set/clear collision.** `rset`==`rclear`≠0 in the same cycle cannot occur, because the WAW check stalls any rd still locked.

## Timing
- **Reset values:**
  - state=`SWEEP`, `sweep_idx`=1, `rr_ptr`=0, `stall_cnt`=0.
  - While `rst_n`=0: `id_ready`=0, `iss_valid`=0, `rset`=0, `wb_gnt`=0.
- **Reset mid-operation:** asserting `rst_n` in any cycle aborts `RUN` or a partial sweep. On release the full sweep restarts from index 1.
- **Sweep duration:** first issue is possible in cycle XN-1 after reset release; cycles are counted from 0.
- **Issue latency:** 0 cycles. Issue and `rset` are in the same cycle, and the lock is visible in `rlocks` the next cycle.
- **Writeback latency:** `wb_gnt` and `rclear` are in the same cycle as the winning `wb_req`, and the lock clears the next cycle. An FU that is not granted keeps `wb_req` and `wb_rd` stable.
- **Stable offer:** `id_*` are held stable while `id_valid` & !`id_ready`.

## Structure
- Package `issue_pkg` holds:
  - `sched_state_t` enum {`SWEEP`, `RUN`};
  - `localparam` defaults for XWDT/XN.
- Sub-module `wb_rr_arb`, parameterised by NFU:
  - inputs: request vector;
  - outputs: one-hot grant and grant index;
  - owns the pointer register;
  - enable input, tied to state==`RUN`.
- Hazard logic, sweep counter and `stall_cnt` live in `issue_sched`.

## Test plan
- **Reset sweep:** release `rst_n` with XN=64 → `rclear` steps 1..63 over 63 cycles with `id_ready`=0, then `RUN`.
- **RAW stall:** `rlocks[5]`=1, offer rs1=5 with use_rs1=1 and `iss_ready`=1 → `id_ready`=0 and `stall_cnt` increments. Clear `rlocks[5]` → issue the next cycle.
- **Unused and zero operands:** `rlocks[5]`=1, offer rs1=5 with use_rs1=0, rd=0 → issue immediately with `rset`=0.
- **WAW plus issue:** offer rd=7 while `rlocks[7]`=1 → stall. After the clear, the instruction fires with `rset`=7 in the same cycle as `iss_valid`.
- **Round-robin fairness:** NFU=2, both `wb_req` held high with rd 3 and 9 → grants alternate FU0, FU1, FU0 and `rclear` alternates 3, 9, 3.
- **Reset mid-operation:** assert `rst_n`=0 during `RUN` with `wb_req`=2'b11 → outputs go to reset values immediately. After release, the sweep restarts at 1 and `rr_ptr`=0.
